// File: rtl/chain_codec_pkg.sv
// Shared constants, state encoding and chain arithmetic for the chained XOR-add byte codec.
// e[n] = d[n] ^ (d[n-1] + KEY) with d[-1] = SEED; decoding applies the same step with the roles swapped.
package chain_codec_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_KEY = 8'h22;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = 8'h03;
  localparam logic [DEF_WIDTH-1:0] DEF_SYNC_BYTE = 8'h55;
  localparam int unsigned DEF_FRAME_LEN = 16;

  // Frame length is at most 255, so an 8-bit byte counter always suffices.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One chain step: the result is data_byte ^ (prev + KEY), with the carry dropped.
  function automatic logic [DEF_WIDTH-1:0] chain_step(input logic [DEF_WIDTH-1:0] prev,
                                                      input logic [DEF_WIDTH-1:0] data_byte);
    return data_byte ^ DEF_WIDTH'(prev + DEF_KEY);
  endfunction

endpackage

// File: rtl/chain_decoder_q3.sv
// Receive-side chained XOR-add decoder: hunts for a sync byte, then decodes a fixed-length
// frame through a single registered output slot with valid/ready on both sides.
module chain_decoder_q3
  import chain_codec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] KEY = WIDTH'(DEF_KEY),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(DEF_SYNC_BYTE),
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_last,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             frame_last_q, frame_last_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] decoded;
  logic             accept;

  // Next-state, handshake and output-slot update.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    frame_last_d = frame_last_q && out_valid_d;
    sync_err_d   = 1'b0;
    in_ready     = 1'b1;
    accept       = 1'b0;
    decoded      = in_data ^ WIDTH'(prev_q + KEY);

    unique case (state_q)
      HUNT: begin
        // The output slot keeps draining here; a held last byte does not block the sync.
        accept = in_valid;
        if (accept) begin
          if (in_data == SYNC_BYTE) begin
            state_d = RUN;
            prev_d  = SEED;
            count_d = '0;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          prev_d       = decoded;
          out_data_d   = decoded;
          out_valid_d  = 1'b1;
          frame_last_d = (count_q == LAST_IDX);
          if (count_q == LAST_IDX) begin
            state_d = HUNT;
            count_d = '0;
          end else begin
            count_d = CNT_W'(count_q + 1'b1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= HUNT;
      prev_q       <= SEED;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_last_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_last_q <= frame_last_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_last = frame_last_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_chain_decoder_q3.sv
// Bench for chain_decoder_q3: directed decode/boundary/backpressure/reset steps, then random
// frames with junk and random handshakes, scored against the known plaintext of each frame.
module tb_chain_decoder_q3;

  localparam logic [7:0] KEY  = 8'h22;
  localparam logic [7:0] SEED = 8'h03;
  localparam logic [7:0] SYNC = 8'h55;
  localparam int FLEN = 16;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       in_valid, in_ready, out_valid, out_ready, frame_last, sync_err;
  logic [7:0] in_data, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chain_decoder_q3 dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_last(frame_last),
    .sync_err  (sync_err)
  );

  function automatic logic [7:0] enc(input logic [7:0] plain, input logic [7:0] prev);
    logic [8:0] sum;
    sum = {1'b0, prev} + {1'b0, KEY};
    return plain ^ sum[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] e);
    drive(1'b1, e, 1'b1);
    tick();
  endtask

  logic [7:0] stream[$];
  logic [8:0] expq[$];
  logic [8:0] item;
  logic [7:0] prev, plain, junk;
  logic       v, r;
  int         idx, exp_err, got_err, cyc;

  initial begin
    // Reset values
    clear_n = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_last", frame_last, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_in_ready_hunt", in_ready, 1);
    @(negedge clk);
    clear_n = 1'b1;
    tick();

    // Basic decode
    send(SYNC);
    check("t1_sync_not_forwarded", out_valid, 0);
    send(8'h35);
    check("t1_valid0", out_valid, 1);
    check("t1_data0", out_data, 8'h10);
    check("t1_last0", frame_last, 0);
    send(8'h99);
    check("t1_data1", out_data, 8'hAB);

    // Carry wrap and an in-frame sync value
    send(enc(8'hF0, 8'hAB));
    check("t2_data_f0", out_data, 8'hF0);
    send(8'h12);
    check("t2_wrap_zero", out_data, 8'h00);
    send(8'h77);
    check("t2_sync_as_data", out_data, 8'h55);
    check("t2_sync_as_data_valid", out_valid, 1);

    // Rest of the frame: frame_last only on byte 16
    prev = 8'h55;
    for (int i = 6; i <= FLEN; i++) begin
      plain = 8'(i * 7 + 1);
      send(enc(plain, prev));
      prev = plain;
      check("t4_frame_data", out_data, plain);
      check("t4_frame_last", frame_last, (i == FLEN) ? 1 : 0);
    end

    // Hunting discards bytes with one sync_err pulse each
    send(8'h00);
    check("t3_err_00", sync_err, 1);
    check("t3_no_out", out_valid, 0);
    check("t3_last_clear", frame_last, 0);
    send(8'hFF);
    check("t3_err_ff", sync_err, 1);
    send(8'hAA);
    check("t3_err_aa", sync_err, 1);
    send(SYNC);
    check("t3_sync_no_err", sync_err, 0);
    check("t3_sync_no_out", out_valid, 0);

    // New frame restarts from SEED
    send(8'h35);
    check("t4_reseed", out_data, 8'h10);

    // Backpressure holds the slot and stalls input
    drive(1'b1, enc(8'h20, 8'h10), 1'b0);
    #1;
    check("t5_stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_valid", out_valid, 1);
      check("t5_hold_data", out_data, 8'h10);
      check("t5_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("t5_release_ready", in_ready, 1);
    tick();
    check("t5_release_data", out_data, 8'h20);
    send(enc(8'h30, 8'h20));
    check("t5_next_data", out_data, 8'h30);
    send(enc(8'h40, 8'h30));
    send(enc(8'h50, 8'h40));
    check("t6_byte5", out_data, 8'h50);

    // Asynchronous reset mid-frame
    drive(1'b0, 8'h00, 1'b0);
    #3;
    clear_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_last", frame_last, 0);
    check("t6_rst_err", sync_err, 0);
    #2;
    clear_n = 1'b1;
    tick();
    send(enc(8'h60, 8'h50));
    check("t6_hunt_err0", sync_err, 1);
    check("t6_hunt_no_out0", out_valid, 0);
    send(8'h34);
    check("t6_hunt_err1", sync_err, 1);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("t6_err_pulse_end", sync_err, 0);

    // Random frames, junk and handshakes against a plaintext scoreboard
    exp_err = 0;
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h00;
        stream.push_back(junk);
        exp_err++;
      end
      stream.push_back(SYNC);
      prev = SEED;
      for (int i = 0; i < FLEN; i++) begin
        plain = 8'($urandom);
        stream.push_back(enc(plain, prev));
        expq.push_back({(i == FLEN - 1), plain});
        prev = plain;
      end
    end

    idx = 0;
    got_err = 0;
    cyc = 0;
    while ((idx < stream.size() || expq.size() > 0) && cyc < 5000) begin
      got_err += int'(sync_err);
      r = ($urandom_range(0, 3) != 0);
      v = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
      drive(v, v ? stream[idx] : 8'h00, r);
      #1;
      if (out_valid && r) begin
        if (expq.size() == 0) begin
          check("rnd_extra_output", out_valid, 0);
        end else begin
          item = expq.pop_front();
          check("rnd_data", out_data, item[7:0]);
          check("rnd_last", frame_last, item[8]);
        end
      end
      if (v && in_ready) idx++;
      tick();
      cyc++;
    end
    got_err += int'(sync_err);
    drive(1'b0, 8'h00, 1'b1);
    check("rnd_stream_consumed", idx, stream.size());
    check("rnd_outputs_drained", expq.size(), 0);
    check("rnd_sync_err_count", got_err, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chain_decoder_q3.md
Name: chain_decoder_q3

Overview:
Receive-side decoder for the chained XOR-add byte encoder. The encoder computes e[n] = d[n] ^ (d[n-1] + KEY), with d[-1] = SEED.
This block hunts for a sync byte, then decodes a fixed-length frame of encoded bytes back to plaintext. It sits between the serial/byte link and the consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, data byte width
KEY, 8'h22, additive chain constant
SEED, 8'h03, chain seed loaded at frame start
SYNC_BYTE, 8'h55, frame start marker (not encoded, not forwarded)
FRAME_LEN, 16, encoded bytes per frame after the sync byte (range 1..255)

Ports:
clk  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream byte valid
in_ready  out  1  block accepts the byte this cycle
in_data  in  WIDTH  encoded byte or sync byte
out_valid  out  1  decoded byte valid
out_ready  in  1  downstream accepts the byte
out_data  out  WIDTH  decoded plaintext byte
frame_last  out  1  qualifies out_data as the final byte of the frame (valid only with out_valid)
sync_err  out  1  one-cycle pulse per byte discarded while hunting

Behaviour:
- Reset is asynchronous and active-low on clear_n. One clock, clk; all state updates on its rising edge.
- Reset values:
  - state = HUNT; prev = SEED; count = 0
  - out_valid = 0; out_data = 0; frame_last = 0; sync_err = 0
- Accept rule: a byte is accepted when in_valid && in_ready.
- in_ready:
  - HUNT: always 1.
  - RUN: !out_valid || out_ready (single output register; a byte can be accepted in the same cycle the held byte drains).
- FSM, HUNT:
  - Accepted byte == SYNC_BYTE -> RUN; prev <= SEED; count <= 0; no output.
  - Accepted byte != SYNC_BYTE -> stay in HUNT; sync_err = 1 next cycle (registered pulse, one cycle per discarded byte).
- FSM, RUN: for each accepted byte e:
  - d = e ^ ((prev + KEY) mod 2^WIDTH); carry out is dropped.
  - prev <= d; out_data <= d; out_valid <= 1; count <= count + 1.
  - frame_last <= (count == FRAME_LEN-1).
  - On that last byte: state -> HUNT, count <= 0.
- Sync value inside RUN: a byte equal to SYNC_BYTE is data, not resync.
- Latency: output appears 1 cycle after acceptance.
- Output hold: out_valid && !out_ready holds out_data and frame_last stable, and in_ready = 0 in RUN.
- out_valid clears when out_ready is high and no new byte is accepted that cycle.
- Back-to-back frames: the sync byte can be accepted in HUNT while the last frame byte is still held in the output register. The HUNT in_ready rule applies; the output register is unaffected.
- Reset mid-frame: all state is discarded immediately, including any held output, and the block returns to HUNT.

Decomposition:
- Package chain_codec_pkg:
  - WIDTH, KEY, SEED, SYNC_BYTE, FRAME_LEN defaults
  - state enum {HUNT, RUN}
  - function chain_step(prev, byte) returning byte ^ (prev + KEY), shared with the encoder and the bench model.
- No sub-module needed. The output register is a one-entry buffer; keep it inline.

Test Plan:
1. Basic decode: sync 0x55 then encoded 0x35, 0x99 -> out_data 0x10, then 0xAB (SEED 0x03; prev+KEY values 0x25, 0x32); frame_last = 0.
2. Wrap-around: after plaintext 0xF0 (prev+KEY = 0x12), feed encoded 0x12 -> out_data 0x00; then feed 0x77 (prev+KEY = 0x22) -> out_data 0x55, forwarded as data with no resync.
3. Hunt and error pulses: bytes 0x00, 0xFF, 0x55 -> sync_err pulses exactly twice; RUN is entered after the third byte; no out_valid.
4. Frame boundary: 16 encoded bytes after sync -> frame_last high only with the 16th output. Then 0xAA -> sync_err pulse; 0x55 -> new frame with prev = 0x03.
5. Backpressure: hold out_ready = 0 over 3 in_valid cycles -> in_ready = 0; out_data is stable; no bytes lost. Release -> the remaining bytes decode in order, 1 per cycle.
6. Reset mid-frame: assert clear_n = 0 asynchronously after byte 5 -> out_valid, sync_err and frame_last drop immediately. After release, encoded bytes without a sync produce sync_err only.
